// File: rtl/ram_rd_stream.sv
// rtl/ram_rd_stream.sv - burst read engine driving one RAM port, streaming words out through a credit-limited FIFO
// Reads are only issued when the FIFO is guaranteed room for the returning word.

module ram_rd_stream_fifo #(
    parameter  int CDataLen   = 8,
    parameter  int CFifoDepth = 2,
    localparam int CPtrLen    = $clog2(CFifoDepth),
    localparam int CCntLen    = $clog2(CFifoDepth + 1)
) (
    input  logic                AClk,
    input  logic                AReset,
    input  logic                AClkEn,
    input  logic                AFlush,
    input  logic                APush,
    input  logic [CDataLen-1:0] APushData,
    input  logic                APop,
    output logic [CDataLen-1:0] AData,
    output logic                AValid,
    output logic [CCntLen-1:0]  ACount
);

    logic [CDataLen-1:0] mem [CFifoDepth];
    logic [CPtrLen-1:0]  wrPtr;
    logic [CPtrLen-1:0]  rdPtr;
    logic [CCntLen-1:0]  count;
    logic                popEff;
    logic                full;

    function automatic logic [CPtrLen-1:0] ptrInc(input logic [CPtrLen-1:0] ptr);
        return (ptr == CPtrLen'(CFifoDepth - 1)) ? '0 : ptr + CPtrLen'(1);
    endfunction

    // Head is forced to zero when empty so a flushed or reset FIFO presents clean data.
    always_comb begin
        popEff = APop && (count != '0);
        full   = (count == CCntLen'(CFifoDepth));
        AValid = (count != '0);
        AData  = (count != '0) ? mem[rdPtr] : '0;
        ACount = count;
    end

    always_ff @(posedge AClk) begin
        if (AClkEn) begin
            if (AReset || AFlush) begin
                wrPtr <= '0;
                rdPtr <= '0;
                count <= '0;
            end else begin
                if (APush) begin
                    wrPtr <= ptrInc(wrPtr);
                end
                if (popEff) begin
                    rdPtr <= ptrInc(rdPtr);
                end
                if (APush && !popEff) begin
                    count <= count + CCntLen'(1);
                end else if (!APush && popEff) begin
                    count <= count - CCntLen'(1);
                end
            end
        end
    end

    always_ff @(posedge AClk) begin
        if (AClkEn && APush && !AFlush && !AReset) begin
            mem[wrPtr] <= APushData;
        end
    end

    assert property (@(posedge AClk) disable iff (AReset)
        !(AClkEn && APush && !AFlush && full && !popEff));

endmodule

module ram_rd_stream #(
    parameter int CAddrLen   = 11,
    parameter int CDataLen   = 8,
    parameter int CLenLen    = 12,
    parameter int CFifoDepth = 2
) (
    input  logic                AClk,
    input  logic                AReset,
    input  logic                AClkEn,
    input  logic                AStart,
    input  logic [CAddrLen-1:0] AStartAddr,
    input  logic [CLenLen-1:0]  ALen,
    input  logic                AAbort,
    output logic                ABusy,
    output logic                ADone,
    output logic [CAddrLen-1:0] AMemAddr,
    output logic                AMemRdEn,
    input  logic [CDataLen-1:0] AMemMiso,
    output logic [CDataLen-1:0] AData,
    output logic                AValid,
    input  logic                AReady
);

    localparam int CCntLen = $clog2(CFifoDepth + 1);
    localparam logic [CCntLen:0] COccLimit = (CCntLen + 1)'(CFifoDepth);

    typedef enum logic [1:0] {
        SIdle  = 2'd0,
        SRun   = 2'd1,
        SDrain = 2'd2
    } TState;

    TState               state;
    TState               stateNext;
    logic [CAddrLen-1:0] addrCnt;
    logic [CLenLen-1:0]  remaining;
    logic                inFlight;
    logic [CCntLen-1:0]  fifoCount;
    logic [CCntLen:0]    occupancy;
    logic                pop;
    logic                issue;
    logic                abortNow;
    logic                startNow;
    logic                finishNow;
    logic                doneNext;

    // Occupancy counts buffered words plus the one still on its way back from the RAM.
    always_comb begin
        pop       = AValid && AReady;
        abortNow  = AAbort && (state != SIdle);
        startNow  = AStart && !AAbort && (state == SIdle);
        occupancy = {1'b0, fifoCount} + {{CCntLen{1'b0}}, inFlight} - {{CCntLen{1'b0}}, pop};
        issue     = (state == SRun) && (remaining != '0) && (occupancy < COccLimit);
        finishNow = (state == SDrain) && !AAbort && !inFlight && pop
                    && (fifoCount == CCntLen'(1));
        doneNext  = (startNow && (ALen == '0)) || finishNow;
        AMemRdEn  = issue;
        AMemAddr  = addrCnt;
        ABusy     = (state != SIdle);
    end

    always_comb begin
        stateNext = state;
        case (state)
            SIdle: begin
                if (startNow && (ALen != '0)) begin
                    stateNext = SRun;
                end
            end
            SRun: begin
                if (AAbort) begin
                    stateNext = SIdle;
                end else if (issue && (remaining == CLenLen'(1))) begin
                    stateNext = SDrain;
                end
            end
            SDrain: begin
                if (AAbort || finishNow) begin
                    stateNext = SIdle;
                end
            end
            default: stateNext = SIdle;
        endcase
    end

    always_ff @(posedge AClk) begin
        if (AClkEn) begin
            if (AReset) begin
                state <= SIdle;
            end else begin
                state <= stateNext;
            end
        end
    end

    always_ff @(posedge AClk) begin
        if (AClkEn) begin
            if (AReset) begin
                addrCnt   <= '0;
                remaining <= '0;
                inFlight  <= 1'b0;
                ADone     <= 1'b0;
            end else begin
                ADone    <= doneNext;
                inFlight <= issue && !abortNow;
                if (startNow) begin
                    addrCnt   <= AStartAddr;
                    remaining <= ALen;
                end else if (issue) begin
                    addrCnt   <= addrCnt + CAddrLen'(1);
                    remaining <= remaining - CLenLen'(1);
                end
            end
        end
    end

    // A read returning after an abort is dropped because inFlight was cleared.
    ram_rd_stream_fifo #(
        .CDataLen   (CDataLen),
        .CFifoDepth (CFifoDepth)
    ) outFifo (
        .AClk      (AClk),
        .AReset    (AReset),
        .AClkEn    (AClkEn),
        .AFlush    (abortNow),
        .APush     (inFlight),
        .APushData (AMemMiso),
        .APop      (pop),
        .AData     (AData),
        .AValid    (AValid),
        .ACount    (fifoCount)
    );

endmodule
